// File: rtl/bus_verteiler_pkg.sv
// bus_verteiler_pkg
// Shared definitions for the bus distributor: access-state enum, IO write-mode
// codes and the address bit that selects the IO space instead of RAM.
package bus_verteiler_pkg;

  typedef enum logic [1:0] {
    BEREIT     = 2'd0,
    RAM_WARTEN = 2'd1,
    QUITTUNG   = 2'd2,
    ABSCHLUSS  = 2'd3
  } zustand_t;

  // IO write modes, taken from DatenAdresse[5:4]
  localparam logic [1:0] LADEN    = 2'b00;  // load
  localparam logic [1:0] SETZEN   = 2'b01;  // OR
  localparam logic [1:0] LOESCHEN = 2'b10;  // AND NOT
  localparam logic [1:0] KIPPEN   = 2'b11;  // XOR

  localparam int IO_AUSWAHL_BIT = 31;

  function automatic logic istIoAdresse(input logic [31:0] adresse);
    return adresse[IO_AUSWAHL_BIT];
  endfunction

endpackage

// File: rtl/io_register_bank.sv
// io_register_bank
// Holds the KANAELE output channel registers and applies the four write modes.
// Ports:
//   Clock, Reset        rising-edge clock, synchronous active-high reset
//   SchreibFreigabe     apply a write to channel Kanal this edge
//   Kanal, Modus        channel index and write mode
//   SchreibWert         write operand
//   LeseWert            current value of channel Kanal (0 if out of range)
//   KanalGueltig        Kanal < KANAELE
//   IoAusgang           all channel registers concatenated, channel 0 in LSBs
module io_register_bank
  import bus_verteiler_pkg::*;
#(
  parameter int KANAELE   = 4,
  parameter int IO_BREITE = 8
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic                         SchreibFreigabe,
  input  logic [3:0]                   Kanal,
  input  logic [1:0]                   Modus,
  input  logic [IO_BREITE-1:0]         SchreibWert,
  output logic [IO_BREITE-1:0]         LeseWert,
  output logic                         KanalGueltig,
  output logic [KANAELE*IO_BREITE-1:0] IoAusgang
);

  logic [IO_BREITE-1:0] kanalReg [KANAELE];
  logic [IO_BREITE-1:0] naechsterWert;

  assign KanalGueltig = ({28'd0, Kanal} < 32'(KANAELE));

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    LeseWert = '0;
    for (int i = 0; i < KANAELE; i++) begin
      if (Kanal == 4'(i)) LeseWert = kanalReg[i];
    end
  end

  always_comb begin
    naechsterWert = SchreibWert;
    case (Modus)
      LADEN:    naechsterWert = SchreibWert;
      SETZEN:   naechsterWert = LeseWert | SchreibWert;
      LOESCHEN: naechsterWert = LeseWert & ~SchreibWert;
      KIPPEN:   naechsterWert = LeseWert ^ SchreibWert;
      default:  naechsterWert = SchreibWert;
    endcase
  end

  // NOTE: the channel registers drive output pins directly, so unlike a RAM
  // array they are individual flops and every one of them is cleared by reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < KANAELE; i++) kanalReg[i] <= '0;
    end else if (SchreibFreigabe) begin
      for (int i = 0; i < KANAELE; i++) begin
        if (Kanal == 4'(i)) kanalReg[i] <= naechsterWert;
      end
    end
  end

  for (genvar g = 0; g < KANAELE; g++) begin : g_ausgang
    assign IoAusgang[g*IO_BREITE +: IO_BREITE] = kanalReg[g];
  end

endmodule

// File: rtl/bus_verteiler.sv
// bus_verteiler
// Splits CPU data accesses between a handshaked RAM (DatenAdresse[31]=0) and a
// bank of memory-mapped output channels (DatenAdresse[31]=1, channel in [3:0],
// write mode in [5:4]). Each request is acknowledged exactly once; a request
// held past its acknowledge does not start a second access.
// Optional feature: define BUS_VERTEILER_TIMEOUT_EN to abandon a RAM access
// after TIMEOUT_ZYKLEN wait cycles (acknowledged with Fehler, read data 0).
// Ports:
//   Clock, Reset                     rising-edge clock, sync active-high reset
//   DatenAdresse, DatenRaus          CPU address / write data
//   LeseDaten, SchreibeDaten         CPU requests, held until acknowledged
//   DatenRein                        registered read data
//   DatenGeladen, DatenGespeichert   one-cycle read / write acknowledge
//   RamAdresse, RamDatenRaus         latched RAM address / write data
//   RamLesen, RamSchreiben           RAM strobes
//   RamDatenRein                     RAM read data
//   RamBereit, RamGeschrieben        RAM read / write done
//   IoAusgang                        channel registers, channel 0 in LSBs
//   Fehler                           one-cycle error pulse with the acknowledge
module bus_verteiler
  import bus_verteiler_pkg::*;
#(
  parameter int KANAELE        = 4,
  parameter int IO_BREITE      = 8,
  parameter int RAM_ADRESSBITS = 8,
  parameter int TIMEOUT_ZYKLEN = 15
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic [31:0]                  DatenAdresse,
  input  logic [31:0]                  DatenRaus,
  input  logic                         LeseDaten,
  input  logic                         SchreibeDaten,
  output logic [31:0]                  DatenRein,
  output logic                         DatenGeladen,
  output logic                         DatenGespeichert,
  output logic [RAM_ADRESSBITS-1:0]    RamAdresse,
  output logic [31:0]                  RamDatenRaus,
  output logic                         RamLesen,
  output logic                         RamSchreiben,
  input  logic [31:0]                  RamDatenRein,
  input  logic                         RamBereit,
  input  logic                         RamGeschrieben,
  output logic [KANAELE*IO_BREITE-1:0] IoAusgang,
  output logic                         Fehler
);

  zustand_t             zustand;
  logic                 istSchreiben;
  logic                 anfrage;
  logic                 ioZugriff;
  logic                 ioSchreibFreigabe;
  logic                 kanalGueltig;
  logic [IO_BREITE-1:0] ioLeseWert;
  logic                 ramFertig;
  logic                 unusedBits;

  assign anfrage   = LeseDaten | SchreibeDaten;
  assign ioZugriff = istIoAdresse(DatenAdresse);
  // Only part of the address is decoded; fold the rest into one ignored bit.
  assign unusedBits = ^DatenAdresse;

  // IO writes land on the same edge that accepts the request; both requests
  // high counts as a write.
  assign ioSchreibFreigabe = (zustand == BEREIT) && SchreibeDaten && ioZugriff && kanalGueltig;
  assign ramFertig         = istSchreiben ? RamGeschrieben : RamBereit;

  io_register_bank #(
    .KANAELE  (KANAELE),
    .IO_BREITE(IO_BREITE)
  ) u_io_register_bank (
    .Clock          (Clock),
    .Reset          (Reset),
    .SchreibFreigabe(ioSchreibFreigabe),
    .Kanal          (DatenAdresse[3:0]),
    .Modus          (DatenAdresse[5:4]),
    .SchreibWert    (DatenRaus[IO_BREITE-1:0]),
    .LeseWert       (ioLeseWert),
    .KanalGueltig   (kanalGueltig),
    .IoAusgang      (IoAusgang)
  );

`ifdef BUS_VERTEILER_TIMEOUT_EN
  localparam int ZW = $clog2(TIMEOUT_ZYKLEN + 1);
  logic [ZW-1:0] wartezaehler;
  logic          zeitAbgelaufen;
  assign zeitAbgelaufen = (wartezaehler == ZW'(TIMEOUT_ZYKLEN - 1));
`else
  localparam int unusedTimeout = TIMEOUT_ZYKLEN;
`endif

  // Acknowledges and Fehler are registered: set on the edge entering QUITTUNG
  // and cleared by the default on the following edge.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      zustand          <= BEREIT;
      istSchreiben     <= 1'b0;
      DatenRein        <= '0;
      DatenGeladen     <= 1'b0;
      DatenGespeichert <= 1'b0;
      RamAdresse       <= '0;
      RamDatenRaus     <= '0;
      RamLesen         <= 1'b0;
      RamSchreiben     <= 1'b0;
      Fehler           <= 1'b0;
`ifdef BUS_VERTEILER_TIMEOUT_EN
      wartezaehler     <= '0;
`endif
    end else begin
      DatenGeladen     <= 1'b0;
      DatenGespeichert <= 1'b0;
      Fehler           <= 1'b0;

      case (zustand)
        BEREIT: begin
          if (anfrage) begin
            RamAdresse   <= DatenAdresse[RAM_ADRESSBITS-1:0];
            RamDatenRaus <= DatenRaus;
            istSchreiben <= SchreibeDaten;
            if (ioZugriff) begin
              zustand <= QUITTUNG;
              Fehler  <= ~kanalGueltig;
              if (SchreibeDaten) begin
                DatenGespeichert <= 1'b1;
              end else begin
                DatenGeladen <= 1'b1;
                DatenRein    <= kanalGueltig ? 32'(ioLeseWert) : 32'd0;
              end
            end else begin
              zustand      <= RAM_WARTEN;
              RamLesen     <= ~SchreibeDaten;
              RamSchreiben <= SchreibeDaten;
`ifdef BUS_VERTEILER_TIMEOUT_EN
              wartezaehler <= '0;
`endif
            end
          end
        end

        RAM_WARTEN: begin
          if (ramFertig) begin
            zustand      <= QUITTUNG;
            RamLesen     <= 1'b0;
            RamSchreiben <= 1'b0;
            if (istSchreiben) begin
              DatenGespeichert <= 1'b1;
            end else begin
              DatenGeladen <= 1'b1;
              DatenRein    <= RamDatenRein;
            end
`ifdef BUS_VERTEILER_TIMEOUT_EN
          end else if (zeitAbgelaufen) begin
            // RAM never answered: close the access with an error.
            zustand      <= QUITTUNG;
            RamLesen     <= 1'b0;
            RamSchreiben <= 1'b0;
            Fehler       <= 1'b1;
            if (istSchreiben) begin
              DatenGespeichert <= 1'b1;
            end else begin
              DatenGeladen <= 1'b1;
              DatenRein    <= '0;
            end
          end else begin
            wartezaehler <= wartezaehler + 1'b1;
`endif
          end
        end

        QUITTUNG: zustand <= ABSCHLUSS;

        // Wait for the CPU to drop its request so a held request is not
        // mistaken for a new one.
        ABSCHLUSS: begin
          if (!anfrage) zustand <= BEREIT;
        end

        default: zustand <= BEREIT;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_verteiler.sv
module tb_bus_verteiler;

  localparam int KANAELE        = 4;
  localparam int IO_BREITE      = 8;
  localparam int RAM_ADRESSBITS = 8;
  localparam int TIMEOUT_ZYKLEN = 15;

  logic                         Clock = 1'b0;
  logic                         Reset;
  logic [31:0]                  DatenAdresse;
  logic [31:0]                  DatenRaus;
  logic                         LeseDaten;
  logic                         SchreibeDaten;
  logic [31:0]                  DatenRein;
  logic                         DatenGeladen;
  logic                         DatenGespeichert;
  logic [RAM_ADRESSBITS-1:0]    RamAdresse;
  logic [31:0]                  RamDatenRaus;
  logic                         RamLesen;
  logic                         RamSchreiben;
  logic [31:0]                  RamDatenRein;
  logic                         RamBereit;
  logic                         RamGeschrieben;
  logic [KANAELE*IO_BREITE-1:0] IoAusgang;
  logic                         Fehler;

  bus_verteiler #(
    .KANAELE       (KANAELE),
    .IO_BREITE     (IO_BREITE),
    .RAM_ADRESSBITS(RAM_ADRESSBITS),
    .TIMEOUT_ZYKLEN(TIMEOUT_ZYKLEN)
  ) dut (
    .Clock           (Clock),
    .Reset           (Reset),
    .DatenAdresse    (DatenAdresse),
    .DatenRaus       (DatenRaus),
    .LeseDaten       (LeseDaten),
    .SchreibeDaten   (SchreibeDaten),
    .DatenRein       (DatenRein),
    .DatenGeladen    (DatenGeladen),
    .DatenGespeichert(DatenGespeichert),
    .RamAdresse      (RamAdresse),
    .RamDatenRaus    (RamDatenRaus),
    .RamLesen        (RamLesen),
    .RamSchreiben    (RamSchreiben),
    .RamDatenRein    (RamDatenRein),
    .RamBereit       (RamBereit),
    .RamGeschrieben  (RamGeschrieben),
    .IoAusgang       (IoAusgang),
    .Fehler          (Fehler)
  );

  always #5 Clock = ~Clock;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: channel contents and the last completed read value.
  logic [IO_BREITE-1:0] modellKanal [KANAELE];
  logic [31:0]          modellDatenRein;

  task automatic pruefe(input string tag, input logic [63:0] ist, input logic [63:0] soll);
    compared++;
    if (ist !== soll) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, ist, soll);
    end
  endtask

  function automatic logic [KANAELE*IO_BREITE-1:0] sollIoAusgang();
    logic [KANAELE*IO_BREITE-1:0] r;
    for (int i = 0; i < KANAELE; i++) r[i*IO_BREITE +: IO_BREITE] = modellKanal[i];
    return r;
  endfunction

  task automatic takt();
    @(posedge Clock);
    #1;
  endtask

  task automatic modellReset();
    for (int i = 0; i < KANAELE; i++) modellKanal[i] = '0;
    modellDatenRein = '0;
  endtask

  // One complete CPU access. ramVerz: cycles the RAM strobe is high before the
  // RAM signals done. halten: extra cycles the request is held after the ack.
  task automatic zugriff(input bit schreiben, input logic [31:0] adr, input logic [31:0] daten,
                         input int ramVerz, input logic [31:0] ramWert, input int halten);
    bit                   istIo    = adr[31];
    int                   kanal    = int'(adr[3:0]);
    bit                   gueltig  = kanal < KANAELE;
    bit                   zeitAus  = 1'b0;
    int                   sollLatenz;
    int                   n        = 0;
    int                   ackZeit  = -1;
    int                   extra    = 0;
    logic [IO_BREITE-1:0] op       = daten[IO_BREITE-1:0];
    logic [31:0]          sollDaten;

`ifdef BUS_VERTEILER_TIMEOUT_EN
    zeitAus = !istIo && (ramVerz >= TIMEOUT_ZYKLEN);
`endif
    sollLatenz = istIo ? 1 : (zeitAus ? TIMEOUT_ZYKLEN + 1 : ramVerz + 2);

    if (!schreiben) begin
      if (istIo)        sollDaten = gueltig ? 32'(modellKanal[kanal]) : 32'd0;
      else if (zeitAus) sollDaten = 32'd0;
      else              sollDaten = ramWert;
    end else begin
      sollDaten = modellDatenRein;
    end

    DatenAdresse  = adr;
    DatenRaus     = daten;
    SchreibeDaten = schreiben;
    LeseDaten     = !schreiben;

    while (ackZeit < 0 && n < 60) begin
      takt();
      n++;
      RamBereit      = schreiben ? 1'($urandom_range(0, 1)) : 1'b0;
      RamGeschrieben = schreiben ? 1'b0 : 1'($urandom_range(0, 1));
      RamDatenRein   = $urandom;
      if (!istIo && n == 1) begin
        pruefe("ram_strobes", {RamLesen, RamSchreiben}, schreiben ? 2'b01 : 2'b10);
        pruefe("ram_adresse", RamAdresse, adr[RAM_ADRESSBITS-1:0]);
        if (schreiben) pruefe("ram_daten_raus", RamDatenRaus, daten);
      end
      if (DatenGeladen || DatenGespeichert) begin
        ackZeit = n;
      end else if (!istIo && n == ramVerz + 1) begin
        if (schreiben) RamGeschrieben = 1'b1;
        else begin
          RamBereit    = 1'b1;
          RamDatenRein = ramWert;
        end
      end
    end
    RamBereit      = 1'b0;
    RamGeschrieben = 1'b0;

    if (istIo && gueltig && schreiben) begin
      case (adr[5:4])
        2'b00: modellKanal[kanal] = op;
        2'b01: modellKanal[kanal] = modellKanal[kanal] | op;
        2'b10: modellKanal[kanal] = modellKanal[kanal] & ~op;
        default: modellKanal[kanal] = modellKanal[kanal] ^ op;
      endcase
    end
    if (!schreiben) modellDatenRein = sollDaten;

    pruefe("ack_latenz", ackZeit, sollLatenz);
    if (ackZeit > 0) begin
      pruefe("ack_art", {DatenGeladen, DatenGespeichert}, schreiben ? 2'b01 : 2'b10);
      pruefe("fehler", Fehler, (istIo && !gueltig) || zeitAus);
      pruefe("daten_rein", DatenRein, modellDatenRein);
      pruefe("io_ausgang", IoAusgang, sollIoAusgang());
    end

    for (int h = 0; h < halten; h++) begin
      takt();
      if (DatenGeladen || DatenGespeichert || RamLesen || RamSchreiben || Fehler) extra++;
    end
    LeseDaten     = 1'b0;
    SchreibeDaten = 1'b0;
    for (int h = 0; h < 2; h++) begin
      takt();
      if (DatenGeladen || DatenGespeichert || RamLesen || RamSchreiben || Fehler) extra++;
    end
    pruefe("kein_zweiter_zugriff", extra, 0);
    pruefe("daten_rein_gehalten", DatenRein, modellDatenRein);
  endtask

  initial begin
    int ackZahl;
    logic [31:0] adr;

    Reset          = 1'b1;
    DatenAdresse   = '0;
    DatenRaus      = '0;
    LeseDaten      = 1'b0;
    SchreibeDaten  = 1'b0;
    RamDatenRein   = '0;
    RamBereit      = 1'b0;
    RamGeschrieben = 1'b0;
    modellReset();
    takt();
    takt();
    pruefe("reset_io", IoAusgang, '0);
    pruefe("reset_daten_rein", DatenRein, 32'd0);
    pruefe("reset_steuer", {DatenGeladen, DatenGespeichert, RamLesen, RamSchreiben, Fehler}, 5'd0);
    Reset = 1'b0;
    takt();

    // Load channel 3
    zugriff(1'b1, 32'h8000_0003, 32'h0000_00A5, 0, 32'd0, 0);
    pruefe("kanal3_a5", IoAusgang[31:24], 8'hA5);

    // Channel 0: load 0x30, set 0x0F, toggle 0xFF
    zugriff(1'b1, 32'h8000_0000, 32'h0000_0030, 0, 32'd0, 0);
    zugriff(1'b1, 32'h8000_0010, 32'h0000_000F, 0, 32'd0, 0);
    pruefe("kanal0_setzen", IoAusgang[7:0], 8'h3F);
    zugriff(1'b1, 32'h8000_0030, 32'h0000_00FF, 0, 32'd0, 0);
    pruefe("kanal0_kippen", IoAusgang[7:0], 8'hC0);

    // RAM read with done after 3 strobe cycles
    zugriff(1'b0, 32'h0000_0005, 32'd0, 3, 32'h1234_5678, 0);
    pruefe("ram_lesen_wert", DatenRein, 32'h1234_5678);

    // Out-of-range channel read
    zugriff(1'b0, 32'h8000_000F, 32'd0, 0, 32'd0, 0);
    pruefe("ungueltig_lesen", DatenRein, 32'd0);
    pruefe("ungueltig_io", IoAusgang[31:24], 8'hA5);

    // Out-of-range write and simultaneous requests (write wins)
    zugriff(1'b1, 32'h8000_0007, 32'h0000_0055, 0, 32'd0, 1);
    DatenAdresse  = 32'h8000_0001;
    DatenRaus     = 32'h0000_005A;
    LeseDaten     = 1'b1;
    SchreibeDaten = 1'b1;
    takt();
    pruefe("beide_anfragen", {DatenGeladen, DatenGespeichert}, 2'b01);
    pruefe("beide_io", IoAusgang[15:8], 8'h5A);
    modellKanal[1] = 8'h5A;
    LeseDaten     = 1'b0;
    SchreibeDaten = 1'b0;
    takt();
    takt();

    // Request held 10 cycles after acknowledge
    zugriff(1'b0, 32'h0000_0042, 32'd0, 1, 32'hCAFE_F00D, 10);

    // Reset while in RAM_WARTEN
    DatenAdresse = 32'h0000_0011;
    LeseDaten    = 1'b1;
    takt();
    takt();
    pruefe("vor_reset_strobe", RamLesen, 1'b1);
    Reset = 1'b1;
    takt();
    pruefe("reset_mitten_strobe", {RamLesen, RamSchreiben}, 2'b00);
    pruefe("reset_mitten_io", IoAusgang, '0);
    pruefe("reset_mitten_daten", DatenRein, 32'd0);
    Reset     = 1'b0;
    LeseDaten = 1'b0;
    modellReset();
    ackZahl = 0;
    for (int i = 0; i < 6; i++) begin
      takt();
      if (DatenGeladen || DatenGespeichert || RamLesen) ackZahl++;
    end
    pruefe("reset_kein_ack", ackZahl, 0);

`ifdef BUS_VERTEILER_TIMEOUT_EN
    zugriff(1'b0, 32'h0000_0020, 32'd0, 1000, 32'd0, 0);
    zugriff(1'b1, 32'h0000_0021, 32'h1111_2222, 1000, 32'd0, 0);
`endif

    // Randomized mix of IO and RAM accesses
    for (int t = 0; t < 300; t++) begin
      bit schreiben = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 0) begin
        adr = $urandom;
        adr[31] = 1'b1;
        adr[3:0] = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(KANAELE, 15))
                                                : 4'($urandom_range(0, KANAELE - 1));
      end else begin
        adr = $urandom;
        adr[31] = 1'b0;
      end
      zugriff(schreiben, adr, $urandom, $urandom_range(0, 5), $urandom, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/bus_verteiler.md
BUS_VERTEILER -- requirements
Module: bus_verteiler

Interface
REQ-001 KANAELE, default 4, number of memory-mapped output channels (1..16) SHALL be a parameter.
REQ-002 IO_BREITE, default 8, width of each output channel (1..32) SHALL be a parameter.
REQ-003 RAM_ADRESSBITS, default 8, RAM word-address width SHALL be a parameter.
REQ-004 TIMEOUT_ZYKLEN, default 15, RAM wait limit in cycles SHALL be a parameter.
REQ-005 Clock  in  1  single clock, all logic on rising edge.
REQ-006 Reset  in  1  synchronous, active-high.
REQ-007 DatenAdresse  in  32  CPU data address.
REQ-008 DatenRaus  in  32  CPU write data.
REQ-009 LeseDaten  in  1  CPU read request, held until acknowledged.
REQ-010 SchreibeDaten  in  1  CPU write request, held until acknowledged.
REQ-011 DatenRein  out  32  read data to CPU, registered.
REQ-012 DatenGeladen  out  1  one-cycle read acknowledge.
REQ-013 DatenGespeichert  out  1  one-cycle write acknowledge.
REQ-014 RamAdresse  out  RAM_ADRESSBITS  latched DatenAdresse[RAM_ADRESSBITS-1:0].
REQ-015 RamDatenRaus  out  32  latched write data to RAM.
REQ-016 RamLesen / RamSchreiben  out  1 each  RAM strobes.
REQ-017 RamDatenRein  in  32  RAM read data.
REQ-018 RamBereit / RamGeschrieben  in  1 each  RAM read/write done.
REQ-019 IoAusgang  out  KANAELE*IO_BREITE  concatenated channel registers, channel 0 in LSBs.
REQ-020 Fehler  out  1  one-cycle error pulse.

Function
REQ-021 Decode SHALL be: DatenAdresse[31]=0 -> RAM; =1 -> IO, channel = DatenAdresse[3:0], mode = DatenAdresse[5:4].
REQ-022 IO write modes SHALL be 00 load, 01 set (OR), 10 clear (AND NOT), 11 toggle (XOR), using DatenRaus[IO_BREITE-1:0].
REQ-023 IO read SHALL return the channel register zero-extended to 32 bits, mode ignored.
REQ-024 FSM states SHALL be BEREIT, RAM_WARTEN, QUITTUNG, ABSCHLUSS.
REQ-025 BEREIT: on LeseDaten or SchreibeDaten, latch address, data and type; RAM -> RAM_WARTEN, IO -> QUITTUNG (IO write applied in this same edge).
REQ-026 Both requests high simultaneously SHALL be treated as write only.
REQ-027 RamLesen/RamSchreiben SHALL be high exactly while in RAM_WARTEN for read/write respectively; on RamBereit/RamGeschrieben, capture RamDatenRein (read) and go to QUITTUNG.
REQ-028 QUITTUNG SHALL assert DatenGeladen or DatenGespeichert for exactly one cycle, then go to ABSCHLUSS.
REQ-029 ABSCHLUSS SHALL return to BEREIT only when LeseDaten and SchreibeDaten are both low; a held request SHALL NOT start a second access.
REQ-030 IO latency SHALL be 1 cycle request-to-acknowledge; RAM latency SHALL be RAM wait + 2 cycles.
REQ-031 IO channel index >= KANAELE SHALL acknowledge normally, read 0, leave all registers unchanged, pulse Fehler in the QUITTUNG cycle.
REQ-032 DatenRein SHALL hold its value from acknowledge until the next read completes.

Reset
REQ-033 Reset SHALL force state BEREIT, all IoAusgang bits, DatenRein, strobes, acknowledges and Fehler to 0 on the next edge, including mid-access; an aborted access SHALL NOT be acknowledged.

Configuration
REQ-034 With BUS_VERTEILER_TIMEOUT_EN defined, TIMEOUT_ZYKLEN cycles in RAM_WARTEN without RAM done SHALL go to QUITTUNG with DatenRein=0 and Fehler pulsed; without it, RAM_WARTEN waits indefinitely and no timeout counter exists.

Structure
REQ-035 Package bus_verteiler_pkg SHALL hold the state enum, mode constants (LADEN, SETZEN, LOESCHEN, KIPPEN) and IO select bit index 31.
REQ-036 Channel registers and mode logic SHALL be sub-module io_register_bank.

Verification
REQ-037 Write 0x000000A5 to 0x80000003 -> DatenGespeichert 1 cycle later, IoAusgang[31:24]=0xA5.
REQ-038 Set 0x0F at 0x80000010, toggle 0xFF at 0x80000030 on channel 0 preloaded 0x30 -> 0x3F then 0xC0.
REQ-039 RAM read 0x00000005, RamBereit after 3 cycles with 0x12345678 -> RamAdresse=0x05, DatenRein=0x12345678, DatenGeladen 5 cycles after request.
REQ-040 Read 0x8000000F with KANAELE=4 -> DatenRein=0, Fehler 1 cycle, IoAusgang unchanged.
REQ-041 Request held 10 cycles after acknowledge -> exactly one access; Reset in RAM_WARTEN -> strobes 0 next cycle, no acknowledge.
REQ-042 With BUS_VERTEILER_TIMEOUT_EN, RamBereit never asserted -> acknowledge after 15 wait cycles, DatenRein=0, Fehler pulse.
